// File: rtl/mips_pkg.sv
// mips_pkg: shared constants, IF/ID entry type and fetch FSM states for the MIPS front end.
package mips_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL         = 5'd4;

    typedef enum logic {RUN, HALT} fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        exc;
        logic [31:0] badvaddr;
    } ifid_t;

    function automatic logic addr_fault(input logic [31:0] pc, input logic [31:0] limit);
        return (pc[1:0] != 2'b00) || (pc >= limit);
    endfunction
endpackage

// File: rtl/fetch_perf_counter.sv
// fetch_perf_counter: 32-bit saturating event counter with increment enable.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);
    logic [31:0] count_q, count_d;

    always_comb count_d = (inc && count_q != '1) ? count_q + 32'd1 : count_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else      count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: MIPS IF stage owning the PC and IF/ID register, halting on fetch address faults.
// Define IF_PERF_CNT_EN to add perf_fetched/perf_stalled saturating counters.
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_instr,
    output logic        id_exc,
    output logic [31:0] id_badvaddr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalled
`endif
);
    logic [31:0]  pc_q, pc_d, pc_plus4;
    fetch_state_e state_q, state_d;
    ifid_t        ifid_q, ifid_d, bubble;
    logic         fault, capture;

    assign pc_plus4 = pc_q + 32'd4;
    assign fault    = addr_fault(pc_q, 32'(IMEM_BYTES));
    assign capture  = !redirect_valid && !flush && !stall && state_q == RUN && !fault;

    always_comb begin
        bubble          = ifid_q;
        bubble.valid    = 1'b0;
        bubble.instr    = NOP_INSTR;
        bubble.exc      = 1'b0;
        bubble.badvaddr = '0;
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        ifid_d  = ifid_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = RUN;
            ifid_d  = bubble;
        end else if (flush) begin
            ifid_d = bubble;
            pc_d   = (state_q == RUN && !fault) ? pc_plus4 : pc_q;
        end else if (stall) begin
            ifid_d = ifid_q;
        end else if (state_q == HALT) begin
            ifid_d = bubble;
        end else if (!fault) begin
            ifid_d = '{valid: 1'b1, pc: pc_q, pc4: pc_plus4, instr: imem_dout, exc: 1'b0, badvaddr: '0};
            pc_d   = pc_plus4;
        end else begin
            // Fault entry is emitted once; HALT then feeds bubbles until a redirect.
            ifid_d  = '{valid: 1'b1, pc: pc_q, pc4: pc_plus4, instr: NOP_INSTR, exc: 1'b1, badvaddr: pc_q};
            state_d = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            ifid_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            ifid_q  <= ifid_d;
        end

    assign imem_addr   = pc_q;
    assign id_valid    = ifid_q.valid;
    assign id_pc       = ifid_q.pc;
    assign id_pc4      = ifid_q.pc4;
    assign id_instr    = ifid_q.instr;
    assign id_exc      = ifid_q.exc;
    assign id_badvaddr = ifid_q.badvaddr;

`ifdef IF_PERF_CNT_EN
    fetch_perf_counter u_fetched (.clk(clk), .rst(rst), .inc(capture), .count(perf_fetched));
    fetch_perf_counter u_stalled (.clk(clk), .rst(rst), .inc(stall && !redirect_valid), .count(perf_stalled));
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed plus random stimulus checked against a behavioural fetch model.
module tb_instr_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_dout;
    logic        id_valid, id_exc;
    logic [31:0] id_pc, id_pc4, id_instr, id_badvaddr;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stalled;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_valid, m_exc;
    logic [31:0] m_ipc, m_ipc4, m_instr, m_bad;
    int unsigned m_fetched, m_stalled;

    always #5 clk = ~clk;
    assign imem_dout = 32'h1000_0000 + imem_addr;

    instr_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_dout(imem_dout),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr),
        .id_exc(id_exc), .id_badvaddr(id_badvaddr)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_stalled(perf_stalled)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 8192);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_halt = 0; m_valid = 0; m_exc = 0;
        m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_bad = 0;
        m_fetched = 0; m_stalled = 0;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_instr = 0; m_exc = 0; m_bad = 0;
    endtask

    task automatic model_step();
        if (stall && !redirect_valid) m_stalled++;
        if (redirect_valid) begin
            m_pc = redirect_pc; m_halt = 0; model_bubble();
        end else if (flush) begin
            model_bubble();
            if (!m_halt && !bad_addr(m_pc)) m_pc = m_pc + 4;
        end else if (stall) begin
        end else if (m_halt) begin
            model_bubble();
        end else begin
            m_valid = 1; m_ipc = m_pc; m_ipc4 = m_pc + 4;
            if (bad_addr(m_pc)) begin
                m_instr = 0; m_exc = 1; m_bad = m_pc; m_halt = 1;
            end else begin
                m_instr = 32'h1000_0000 + m_pc; m_exc = 0; m_bad = 0;
                m_pc = m_pc + 4; m_fetched++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"}, imem_addr, m_pc);
        chk({tag, ".valid"}, 32'(id_valid), 32'(m_valid));
        chk({tag, ".instr"}, id_instr, m_instr);
        chk({tag, ".exc"}, 32'(id_exc), 32'(m_exc));
        chk({tag, ".bad"}, id_badvaddr, m_bad);
        if (m_valid) begin
            chk({tag, ".pc"}, id_pc, m_ipc);
            chk({tag, ".pc4"}, id_pc4, m_ipc4);
        end
`ifdef IF_PERF_CNT_EN
        chk({tag, ".pfetch"}, perf_fetched, m_fetched);
        chk({tag, ".pstall"}, perf_stalled, m_stalled);
`endif
    endtask

    task automatic cyc(input string tag, input bit s, input bit f, input bit rv, input logic [31:0] rp);
        stall = s; flush = f; redirect_valid = rv; redirect_pc = rp;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset");
        chk("reset.pc", id_pc, 32'h0);
        chk("reset.pc4", id_pc4, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        cyc("run0", 0, 0, 0, 0);
        chk("run0.pc_abs", id_pc, 32'h0);
        cyc("run1", 0, 0, 0, 0);
        chk("run1.pc_abs", id_pc, 32'h4);
        chk("run1.instr_abs", id_instr, 32'h1000_0004);
        for (int i = 0; i < 3; i++) cyc("stall", 1, 0, 0, 0);
        chk("stall.addr_abs", imem_addr, 32'h8);
`ifdef IF_PERF_CNT_EN
        chk("stall.perf_abs", perf_stalled, 32'd3);
`endif
        cyc("resume0", 0, 0, 0, 0);
        chk("resume0.pc_abs", id_pc, 32'h8);
        cyc("resume1", 0, 0, 0, 0);
        chk("resume1.pc_abs", id_pc, 32'hC);

        cyc("redir_stall", 1, 0, 1, 32'h40);
        chk("redir_stall.addr_abs", imem_addr, 32'h40);
        cyc("redir_next", 0, 0, 0, 0);
        chk("redir_next.pc_abs", id_pc, 32'h40);

        cyc("mis_redir", 0, 0, 1, 32'h42);
        cyc("mis_fault", 0, 0, 0, 0);
        chk("mis_fault.exc_abs", 32'(id_exc), 32'h1);
        chk("mis_fault.bad_abs", id_badvaddr, 32'h42);
        for (int i = 0; i < 3; i++) cyc("mis_halt", 0, 0, 0, 0);
        chk("mis_halt.addr_abs", imem_addr, 32'h42);
        cyc("mis_flush_halt", 0, 1, 0, 0);
        cyc("resume_redir", 0, 0, 1, 32'h100);
        cyc("resume_fetch", 0, 0, 0, 0);
        chk("resume_fetch.pc_abs", id_pc, 32'h100);

        cyc("flush_run", 0, 1, 0, 0);
        chk("flush_run.addr_abs", imem_addr, 32'h108);

        cyc("top_redir", 0, 0, 1, 32'h1FF8);
        for (int i = 0; i < 2; i++) cyc("top_run", 0, 0, 0, 0);
        cyc("top_fault", 0, 0, 0, 0);
        chk("top_fault.bad_abs", id_badvaddr, 32'h2000);
        cyc("top_halt", 0, 0, 0, 0);

        cyc("wrap_redir", 0, 0, 1, 32'hFFFF_FFFC);
        cyc("wrap_fault", 0, 0, 0, 0);
        chk("wrap_fault.pc4_abs", id_pc4, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 4))
                0: tgt = 32'h1FF0;
                1: tgt = {$urandom_range(0, 2047), 2'b00};
                2: tgt = $urandom;
                3: tgt = 32'hFFFF_FFF8;
                default: tgt = {$urandom_range(0, 2047), 2'b10};
            endcase
            cyc("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 11) == 0, tgt);
        end

        stall = 0; flush = 0; redirect_valid = 0;
        @(posedge clk);
        model_step();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2;
        rst = 1'b1;
        cyc("post_rst", 0, 0, 0, 0);
        chk("post_rst.pc_abs", id_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- IF stage of the MIPS pipeline. Sits directly upstream of the instruction memory: owns the PC, drives the memory's fetch address, and captures the returned word into the IF/ID pipeline register.
- Handles stall, flush and redirect inputs from the hazard/branch logic.
- Detects fetch-address faults (misaligned or out of range) and halts fetch until a redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 8192, instruction memory size in bytes; PC at or above this is out of range.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low; one clock domain.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  invalidate IF/ID next edge.
- redirect_valid  in  1  load redirect_pc (branch/jump/exception vector).
- redirect_pc  in  32  target PC.
- imem_addr  out  32  fetch byte address to instruction memory; always equals the PC.
- imem_dout  in  32  instruction word returned combinationally by memory.
- id_valid  out  1  IF/ID holds a real instruction or a fault marker.
- id_pc  out  32  PC of the IF/ID entry.
- id_pc4  out  32  id_pc + 4.
- id_instr  out  32  instruction; 32'h0000_0000 (NOP) when invalid or faulted.
- id_exc  out  1  IF/ID entry carries a fetch address fault.
- id_badvaddr  out  32  faulting PC; 0 when id_exc=0.

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, state=RUN, id_valid=0, id_pc=0, id_pc4=0, id_instr=0, id_exc=0, id_badvaddr=0.
- Reset released mid-fetch: the first posedge after rst rises fetches RESET_PC.
- Fault check (combinational on PC): fault = PC[1:0]!=0 or PC >= IMEM_BYTES.
- States:
  - RUN: fetching normally.
  - HALT: faulted; no fetch.
- Per posedge, priority order:
  1. redirect_valid: PC <= {redirect_pc}; state <= RUN; IF/ID <= bubble (id_valid=0, id_instr=0, id_exc=0). Redirect overrides stall and flush.
  2. flush: IF/ID <= bubble; PC <= PC+4 if state=RUN and no fault, else PC held.
  3. stall: PC, state and IF/ID all held unchanged.
  4. RUN, no fault: IF/ID <= {valid=1, pc=PC, pc4=PC+4, instr=imem_dout, exc=0}; PC <= PC+4.
  5. RUN, fault: IF/ID <= {valid=1, pc=PC, pc4=PC+4, instr=0, exc=1, badvaddr=PC}; PC held; state <= HALT.
  6. HALT: IF/ID <= bubble; PC held.
- Latency: a PC value appears on id_* one cycle after it is presented on imem_addr.
- Arithmetic: PC+4 is a 32-bit wrap-around add; 32'hFFFF_FFFC+4 = 0. That wrapped value is checked for faults like any other PC.
- A fault entry is emitted exactly once; only a redirect leaves HALT.
- redirect_pc is not checked at load; it is checked when it becomes the fetch PC.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, add outputs perf_fetched[31:0] and perf_stalled[31:0]. Both are saturating counters, reset to 0:
  - perf_fetched increments on each rule-4 capture.
  - perf_stalled increments on each cycle with stall=1 and redirect_valid=0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR = 32'h0000_0000.
  - Default RESET_PC.
  - Exception code EXC_ADEL = 5'd4, consumed downstream with id_exc.
  - An fsm enum of {RUN, HALT}.
- One sub-module, fetch_perf_counter: a single saturating 32-bit counter with an inc enable, instantiated twice under IF_PERF_CNT_EN.

Test Plan:
- Reset then free-run with imem returning 32'h1000_0000+addr: id_pc goes 0, 4, 8 on consecutive cycles; id_instr=32'h1000_0004 when id_pc=4; id_pc4=id_pc+4.
- stall held 3 cycles at PC=8: imem_addr stays 8 and id_* are unchanged for 3 cycles; fetch resumes with id_pc=8 then 12.
- redirect_valid=1, redirect_pc=32'h40 together with stall=1: next cycle imem_addr=32'h40 and id_valid=0; the following cycle id_pc=32'h40.
- redirect to 32'h42: id_exc=1, id_badvaddr=32'h42, id_instr=0 for one cycle, then id_valid=0 with PC held at 32'h42; a redirect to 32'h100 resumes fetching.
- Sequential fetch reaching PC=8192 (0x2000): a fault entry with badvaddr=32'h2000 and then HALT. Separately, flush=1 during RUN gives id_valid=0 while the PC still advances by 4.
- Assert rst low asynchronously mid-cycle: all id_* outputs drop to 0 immediately and imem_addr=RESET_PC. With IF_PERF_CNT_EN defined, perf_stalled=3 after the stall scenario.
